// File: rtl/aes_arb_pkg.sv
// Shared types and helpers for the AES core arbiter: controller states,
// block width and the watchdog counter sizing function.
package aes_arb_pkg;

   localparam int AES_BLK_W = 128;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } arb_state_e;

   // Bits needed to count 0..value-1, never less than one.
   function automatic int clog2(input int value);
      int w;
      w = 1;
      while ((1 << w) < value) w++;
      return w;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches upward from pointer+1 (wrapping)
// and returns the first requester found, both one-hot and as an index.
module rr_arbiter
   import aes_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [ID_W-1:0]  pointer_i,
   output logic [N_REQ-1:0] grant_onehot_o,
   output logic [ID_W-1:0]  grant_idx_o
);

   logic            found;
   logic [ID_W-1:0] idx;

   always_comb begin
      grant_onehot_o = '0;
      grant_idx_o    = '0;
      found          = 1'b0;
      idx            = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         idx = ID_W'((int'(pointer_i) + i) % N_REQ);
         if (!found && req_i[idx]) begin
            found               = 1'b1;
            grant_onehot_o[idx] = 1'b1;
            grant_idx_o         = idx;
         end
      end
   end

endmodule

// File: rtl/aes_core_arbiter.sv
// Time-shares one AES encrypt core between N_REQ requesters: round-robin grant,
// one-cycle load pulse, wait for result (with watchdog), then tagged response.
module aes_core_arbiter
   import aes_arb_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int ID_W    = 2,
   parameter int TIMEOUT = 64,
   parameter int KEY_W   = 128
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       key_wr,
   input  logic [KEY_W-1:0]           key_in,
   output logic                       key_wr_ready,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ*AES_BLK_W-1:0] req_pt,
   output logic [N_REQ-1:0]           req_ready,
   output logic                       resp_valid,
   input  logic                       resp_ready,
   output logic [ID_W-1:0]            resp_id,
   output logic [AES_BLK_W-1:0]       resp_ct,
   output logic                       resp_err,
   output logic                       core_load,
   output logic [AES_BLK_W-1:0]       core_pt,
   output logic [KEY_W-1:0]           core_key,
   input  logic [AES_BLK_W-1:0]       core_ct,
   input  logic                       core_valid,
   output logic                       busy
);

   localparam int CNT_W = clog2(TIMEOUT);

   arb_state_e           state_q, state_d;
   logic [ID_W-1:0]      ptr_q, ptr_d;
   logic [KEY_W-1:0]     key_q, key_d;
   logic [AES_BLK_W-1:0] pt_q, pt_d;
   logic [AES_BLK_W-1:0] ct_q, ct_d;
   logic [ID_W-1:0]      id_q, id_d;
   logic                 err_q, err_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   logic [N_REQ-1:0]     gnt_onehot;
   logic [ID_W-1:0]      gnt_idx;
   logic [AES_BLK_W-1:0] pt_sel;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_rr (
      .req_i          (req_valid),
      .pointer_i      (ptr_q),
      .grant_onehot_o (gnt_onehot),
      .grant_idx_o    (gnt_idx)
   );

   // One-hot mux of the granted requester's plaintext.
   always_comb begin
      pt_sel = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt_onehot[i]) pt_sel = pt_sel | req_pt[i*AES_BLK_W +: AES_BLK_W];
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      key_d     = key_q;
      pt_d      = pt_q;
      ct_d      = ct_q;
      id_d      = id_q;
      err_d     = err_q;
      cnt_d     = cnt_q;
      req_ready = '0;
      case (state_q)
         IDLE: begin
            if (key_wr) key_d = key_in;
            if (|req_valid) begin
               req_ready = gnt_onehot;
               pt_d      = pt_sel;
               id_d      = gnt_idx;
               ptr_d     = gnt_idx;
               state_d   = LOAD;
            end
         end
         // core_valid is deliberately not looked at here: a late pulse from
         // the previous operation must not complete this one.
         LOAD: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (core_valid) begin
               ct_d    = core_ct;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               ct_d    = '0;
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RESP: begin
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= ID_W'(N_REQ - 1);
         key_q   <= '0;
         pt_q    <= '0;
         ct_q    <= '0;
         id_q    <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         key_q   <= key_d;
         pt_q    <= pt_d;
         ct_q    <= ct_d;
         id_q    <= id_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign key_wr_ready = (state_q == IDLE);
   assign busy         = (state_q != IDLE);
   assign core_load    = (state_q == LOAD);
   assign resp_valid   = (state_q == RESP);
   assign core_pt      = pt_q;
   assign core_key     = key_q;
   assign resp_ct      = ct_q;
   assign resp_id      = id_q;
   assign resp_err     = err_q;

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Bench for aes_core_arbiter: behavioural core model plus a round-robin
// reference that predicts grants, results, timeouts and key behaviour.
module tb_aes_core_arbiter;

   localparam int N   = 4;
   localparam int IDW = 2;
   localparam int TO  = 64;
   localparam int KW  = 128;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            key_wr = 1'b0;
   logic [KW-1:0]   key_in = '0;
   logic            key_wr_ready;
   logic [N-1:0]    req_valid = '0;
   logic [N*128-1:0] req_pt = '0;
   logic [N-1:0]    req_ready;
   logic            resp_valid;
   logic            resp_ready = 1'b0;
   logic [IDW-1:0]  resp_id;
   logic [127:0]    resp_ct;
   logic            resp_err;
   logic            core_load;
   logic [127:0]    core_pt;
   logic [KW-1:0]   core_key;
   logic [127:0]    core_ct = '0;
   logic            core_valid = 1'b0;
   logic            busy;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int           exp_ptr = N - 1;
   logic [KW-1:0] cur_key = '0;
   logic [127:0] pts [N];

   // Core model controls and observations
   int           lat = 1;
   int           cd = 0;
   logic [127:0] ct_val = '0;
   logic [127:0] ld_pt = '0;
   logic [KW-1:0] ld_key = '0;

   always #5 clk = ~clk;

   aes_core_arbiter #(.N_REQ(N), .ID_W(IDW), .TIMEOUT(TO), .KEY_W(KW)) dut (
      .clk          (clk),
      .rst          (rst),
      .key_wr       (key_wr),
      .key_in       (key_in),
      .key_wr_ready (key_wr_ready),
      .req_valid    (req_valid),
      .req_pt       (req_pt),
      .req_ready    (req_ready),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_id      (resp_id),
      .resp_ct      (resp_ct),
      .resp_err     (resp_err),
      .core_load    (core_load),
      .core_pt      (core_pt),
      .core_key     (core_key),
      .core_ct      (core_ct),
      .core_valid   (core_valid),
      .busy         (busy)
   );

   // Core model: answers lat cycles after the load cycle (lat=0: never answers).
   always @(negedge clk) begin
      core_valid = 1'b0;
      if (cd > 0) begin
         cd = cd - 1;
         if (cd == 0) begin
            core_valid = 1'b1;
            core_ct    = ct_val;
         end
      end
      if (core_load) begin
         ld_pt  = core_pt;
         ld_key = core_key;
         if (lat > 0) cd = lat;
      end
   end

   function automatic int pick(input logic [N-1:0] m, input int p);
      for (int k = 1; k <= N; k++) begin
         if (((m >> ((p + k) % N)) & 1) != 0) return (p + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic set_pt(input int i, input logic [127:0] v);
      pts[i] = v;
      req_pt[i*128 +: 128] = v;
   endtask

   // Runs one operation from an IDLE-cycle negedge (inputs already driven).
   task automatic run_op(input bit hold, input bit stop_vld,
                         output int gidx, output int nbits, output int nload,
                         output int nwait, output logic [IDW-1:0] rid,
                         output logic [127:0] rct, output logic rerr, output bit done);
      bit loaded, clr;
      gidx = -1; nbits = 0; nload = 0; nwait = 0;
      rid = '0; rct = '0; rerr = 1'b0; done = 1'b0;
      loaded = 1'b0; clr = 1'b0;
      for (int c = 0; c < 300; c++) begin
         if (c > 0) begin
            @(negedge clk);
            if (clr) begin
               req_valid = req_valid & ~(N'(1) << gidx);
               clr = 1'b0;
            end
         end
         #1;
         if (req_ready != '0) begin
            nbits += $countones(req_ready);
            for (int i = 0; i < N; i++) if (req_ready[i]) gidx = i;
            if (!hold) clr = 1'b1;
         end
         if (core_load) begin
            nload++;
            loaded = 1'b1;
         end else if (loaded && busy && !resp_valid) begin
            nwait++;
         end
         if (resp_valid && (resp_ready || stop_vld)) begin
            rid = resp_id; rct = resp_ct; rerr = resp_err; done = 1'b1;
            break;
         end
      end
   endtask

   // Steps from an IDLE-cycle negedge to the LOAD cycle, dropping the request after grant.
   task automatic wait_load(output bit ok);
      bit seen;
      ok = 1'b0; seen = 1'b0;
      for (int c = 0; c < 50; c++) begin
         #1;
         if (req_ready != '0) seen = 1'b1;
         if (core_load) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
         if (seen) req_valid = '0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%0b exp=0", resp_valid); end
      checks++; if (core_load !== 1'b0) begin errors++; $display("FAIL reset_core_load got=%0b exp=0", core_load); end
      checks++; if (core_key !== '0) begin errors++; $display("FAIL reset_core_key got=%h exp=0", core_key); end
      checks++; if (key_wr_ready !== 1'b1) begin errors++; $display("FAIL reset_key_wr_ready got=%0b exp=1", key_wr_ready); end
      checks++; if ({resp_id, resp_ct, resp_err} !== '0) begin errors++; $display("FAIL reset_resp_fields id=%0d ct=%h err=%0b exp=0", resp_id, resp_ct, resp_err); end
      @(negedge clk);
      rst = 1'b0;
      exp_ptr = N - 1;
      cur_key = '0;
   endtask

   task automatic test_round_robin();
      int g, nb, nl, nw; logic [IDW-1:0] id; logic [127:0] ct; logic er; bit dn;
      int want;
      resp_ready = 1'b1;
      for (int i = 0; i < N; i++) set_pt(i, rnd128());
      for (int op = 0; op < 5; op++) begin
         @(negedge clk);
         req_valid = '1;
         lat = $urandom_range(1, 6);
         ct_val = rnd128();
         want = pick(req_valid, exp_ptr);
         run_op(1'b1, 1'b0, g, nb, nl, nw, id, ct, er, dn);
         exp_ptr = want;
         checks++; if (g != want || g != (op % N)) begin errors++; $display("FAIL rr_grant op=%0d got=%0d exp=%0d", op, g, want); end
         checks++; if (nb != 1) begin errors++; $display("FAIL rr_ready_bits op=%0d got=%0d exp=1", op, nb); end
         checks++; if (!dn || id !== IDW'(want) || ct !== ct_val) begin errors++; $display("FAIL rr_resp op=%0d done=%0b id=%0d ct=%h exp_id=%0d exp_ct=%h", op, dn, id, ct, want, ct_val); end
         checks++; if (ld_pt !== pts[want]) begin errors++; $display("FAIL rr_core_pt op=%0d got=%h exp=%h", op, ld_pt, pts[want]); end
      end
      @(negedge clk);
      req_valid = '0;
   endtask

   task automatic test_single();
      int g, nb, nl, nw; logic [IDW-1:0] id; logic [127:0] ct; logic er; bit dn;
      logic [127:0] k;
      k = 128'hfefd00d583ef87e9b7e6ab3a655f68db;
      @(negedge clk);
      key_wr = 1'b1; key_in = k;
      @(negedge clk);
      key_wr = 1'b0;
      cur_key = k;
      set_pt(0, 128'h000102030405060708090a0b0c0d0e0f);
      req_valid = 4'b0001;
      lat = 11;
      ct_val = {16{8'hA5}};
      resp_ready = 1'b1;
      run_op(1'b0, 1'b0, g, nb, nl, nw, id, ct, er, dn);
      exp_ptr = 0;
      checks++; if (!dn) begin errors++; $display("FAIL single_done got=0 exp=1"); end
      checks++; if (g != 0 || nb != 1) begin errors++; $display("FAIL single_ready grant=%0d bits=%0d exp grant=0 bits=1", g, nb); end
      checks++; if (nl != 1) begin errors++; $display("FAIL single_core_load pulses=%0d exp=1", nl); end
      checks++; if (id !== 2'd0 || ct !== {16{8'hA5}} || er !== 1'b0) begin errors++; $display("FAIL single_resp id=%0d ct=%h err=%0b exp id=0 ct=a5.. err=0", id, ct, er); end
      checks++; if (ld_pt !== pts[0] || ld_key !== k) begin errors++; $display("FAIL single_core_inputs pt=%h key=%h exp pt=%h key=%h", ld_pt, ld_key, pts[0], k); end
   endtask

   task automatic test_backpressure();
      int g, nb, nl, nw; logic [IDW-1:0] id; logic [127:0] ct; logic er; bit dn;
      int want;
      @(negedge clk);
      set_pt(1, rnd128());
      req_valid = 4'b0010;
      lat = 3;
      ct_val = rnd128();
      resp_ready = 1'b0;
      want = pick(req_valid, exp_ptr);
      run_op(1'b0, 1'b1, g, nb, nl, nw, id, ct, er, dn);
      exp_ptr = want;
      checks++; if (!dn || id !== IDW'(want) || ct !== ct_val) begin errors++; $display("FAIL bp_resp done=%0b id=%0d ct=%h exp_id=%0d exp_ct=%h", dn, id, ct, want, ct_val); end
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         #1;
         checks++;
         if (resp_valid !== 1'b1 || busy !== 1'b1 || core_load !== 1'b0 || resp_id !== IDW'(want) || resp_ct !== ct_val) begin
            errors++;
            $display("FAIL bp_hold cycle=%0d valid=%0b busy=%0b load=%0b id=%0d ct=%h exp valid=1 busy=1 load=0 id=%0d ct=%h",
                     c, resp_valid, busy, core_load, resp_id, resp_ct, want, ct_val);
         end
      end
      @(negedge clk);
      resp_ready = 1'b1;
      #1;
      checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp_accept_cycle valid=%0b exp=1", resp_valid); end
      @(negedge clk);
      #1;
      checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_release valid=%0b busy=%0b exp 0 0", resp_valid, busy); end
   endtask

   task automatic test_timeout();
      int g, nb, nl, nw; logic [IDW-1:0] id; logic [127:0] ct; logic er; bit dn;
      @(negedge clk);
      set_pt(2, rnd128());
      req_valid = 4'b0100;
      lat = 0;
      resp_ready = 1'b1;
      run_op(1'b0, 1'b0, g, nb, nl, nw, id, ct, er, dn);
      exp_ptr = 2;
      checks++; if (!dn || nw != TO) begin errors++; $display("FAIL to_wait_cycles done=%0b got=%0d exp=%0d", dn, nw, TO); end
      checks++; if (er !== 1'b1 || ct !== '0 || id !== 2'd2) begin errors++; $display("FAIL to_resp err=%0b ct=%h id=%0d exp err=1 ct=0 id=2", er, ct, id); end
      @(negedge clk);
      set_pt(3, rnd128());
      req_valid = 4'b1000;
      lat = 2;
      ct_val = rnd128();
      run_op(1'b0, 1'b0, g, nb, nl, nw, id, ct, er, dn);
      exp_ptr = 3;
      checks++; if (!dn || er !== 1'b0 || ct !== ct_val || id !== 2'd3) begin errors++; $display("FAIL to_recover done=%0b err=%0b ct=%h id=%0d exp err=0 ct=%h id=3", dn, er, ct, id, ct_val); end
   endtask

   task automatic test_key_gating();
      int g, nb, nl, nw; logic [IDW-1:0] id; logic [127:0] ct; logic er; bit dn; bit ok;
      @(negedge clk);
      set_pt(0, rnd128());
      req_valid = 4'b0001;
      lat = 20;
      ct_val = rnd128();
      resp_ready = 1'b1;
      wait_load(ok);
      exp_ptr = 0;
      checks++; if (!ok) begin errors++; $display("FAIL kg_load_seen got=0 exp=1"); end
      @(negedge clk);
      key_wr = 1'b1; key_in = 128'h1;
      #1;
      checks++; if (key_wr_ready !== 1'b0) begin errors++; $display("FAIL kg_ready_in_wait got=%0b exp=0", key_wr_ready); end
      @(negedge clk);
      key_wr = 1'b0;
      #1;
      checks++; if (core_key !== cur_key) begin errors++; $display("FAIL kg_key_held got=%h exp=%h", core_key, cur_key); end
      ok = 1'b0;
      for (int c = 0; c < 100; c++) begin
         if (resp_valid) begin ok = 1'b1; break; end
         @(negedge clk);
         #1;
      end
      checks++; if (!ok || resp_err !== 1'b0 || resp_ct !== ct_val) begin errors++; $display("FAIL kg_first_resp seen=%0b err=%0b ct=%h exp_ct=%h", ok, resp_err, resp_ct, ct_val); end
      @(negedge clk);
      key_wr = 1'b1; key_in = 128'h1;
      set_pt(1, rnd128());
      req_valid = 4'b0010;
      lat = 4;
      ct_val = rnd128();
      run_op(1'b0, 1'b0, g, nb, nl, nw, id, ct, er, dn);
      key_wr = 1'b0;
      cur_key = 128'h1;
      exp_ptr = 1;
      checks++; if (!dn || ld_key !== 128'h1 || id !== 2'd1) begin errors++; $display("FAIL kg_idle_write done=%0b key=%h id=%0d exp key=1 id=1", dn, ld_key, id); end
   endtask

   task automatic test_random();
      int g, nb, nl, nw; logic [IDW-1:0] id; logic [127:0] ct; logic er; bit dn;
      logic [N-1:0] pend, nw_mask;
      int want;
      pend = '0;
      resp_ready = 1'b1;
      for (int op = 0; op < 16; op++) begin
         @(negedge clk);
         nw_mask = N'($urandom_range(0, (1 << N) - 1));
         if ((pend | nw_mask) == '0) nw_mask = N'(1) << $urandom_range(0, N - 1);
         for (int i = 0; i < N; i++) begin
            if (nw_mask[i] && !pend[i]) set_pt(i, rnd128());
         end
         pend = pend | nw_mask;
         req_valid = pend;
         if ($urandom_range(0, 3) == 0) begin
            key_wr = 1'b1;
            key_in = rnd128();
            cur_key = key_in;
         end else begin
            key_wr = 1'b0;
         end
         lat = $urandom_range(1, 12);
         ct_val = rnd128();
         want = pick(pend, exp_ptr);
         run_op(1'b0, 1'b0, g, nb, nl, nw, id, ct, er, dn);
         key_wr = 1'b0;
         exp_ptr = want;
         pend = pend & ~(N'(1) << want);
         checks++;
         if (!dn || g != want || id !== IDW'(want) || ct !== ct_val || er !== 1'b0 || ld_pt !== pts[want] || ld_key !== cur_key) begin
            errors++;
            $display("FAIL rand_op op=%0d done=%0b grant=%0d id=%0d err=%0b ct_ok=%0b pt_ok=%0b key_ok=%0b exp grant=%0d",
                     op, dn, g, id, er, ct === ct_val, ld_pt === pts[want], ld_key === cur_key, want);
         end
      end
      @(negedge clk);
      req_valid = '0;
   endtask

   task automatic test_reset_mid_wait();
      int g, nb, nl, nw; logic [IDW-1:0] id; logic [127:0] ct; logic er; bit dn; bit ok; bit bad;
      @(negedge clk);
      set_pt(2, rnd128());
      req_valid = 4'b0100;
      lat = 8;
      ct_val = rnd128();
      wait_load(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rm_load_seen got=0 exp=1"); end
      repeat (2) @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (busy !== 1'b0 || resp_valid !== 1'b0 || core_load !== 1'b0) begin errors++; $display("FAIL rm_async busy=%0b valid=%0b load=%0b exp 0 0 0", busy, resp_valid, core_load); end
      checks++; if (core_key !== '0) begin errors++; $display("FAIL rm_key_clear got=%h exp=0", core_key); end
      @(negedge clk);
      rst = 1'b0;
      exp_ptr = N - 1;
      cur_key = '0;
      bad = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         #1;
         if (resp_valid || busy) bad = 1'b1;
      end
      checks++; if (bad) begin errors++; $display("FAIL rm_late_valid busy_or_resp=1 exp=0"); end
      @(negedge clk);
      for (int i = 0; i < N; i++) set_pt(i, rnd128());
      req_valid = '1;
      lat = 3;
      ct_val = rnd128();
      resp_ready = 1'b1;
      run_op(1'b0, 1'b0, g, nb, nl, nw, id, ct, er, dn);
      exp_ptr = pick(4'b1111, N - 1);
      checks++; if (!dn || g != 0 || id !== 2'd0 || ct !== ct_val) begin errors++; $display("FAIL rm_first_grant done=%0b grant=%0d id=%0d exp=0", dn, g, id); end
      @(negedge clk);
      req_valid = '0;
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single();
      test_backpressure();
      test_timeout();
      test_key_gating();
      test_random();
      test_reset_mid_wait();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
